// File: rtl/fpnew_opgroup_reorder_block_if.sv
// Handshake and completion bus of the opgroup reorder block.
// Signal names match the block's port list; the DUT uses the slave modport.
interface fpnew_opgroup_reorder_block_if #(
    parameter int unsigned NumChannels = 4,
    parameter int unsigned Width       = 32,
    parameter int unsigned Depth       = 4,
    parameter int unsigned TagWidth    = 8
);
    localparam int unsigned IdW = $clog2(Depth);
    localparam int unsigned ChW = (NumChannels > 1) ? $clog2(NumChannels) : 1;

    logic                                flush_i;
    logic                                in_valid_i;
    logic [ChW-1:0]                      in_channel_i;
    logic [TagWidth-1:0]                 in_tag_i;
    logic                                in_ready_o;
    logic [NumChannels-1:0]              ch_valid_o;
    logic [IdW-1:0]                      ch_id_o;
    logic [NumChannels-1:0]              ch_ready_i;
    logic [NumChannels-1:0]              done_valid_i;
    logic [NumChannels-1:0][IdW-1:0]     done_id_i;
    logic [NumChannels-1:0][Width-1:0]   done_result_i;
    logic [NumChannels-1:0][4:0]         done_status_i;
    logic                                out_valid_o;
    logic                                out_ready_i;
    logic [Width-1:0]                    result_o;
    logic [4:0]                          status_o;
    logic [TagWidth-1:0]                 tag_o;
    logic                                busy_o;

    modport slave (
        input  flush_i, in_valid_i, in_channel_i, in_tag_i,
        input  ch_ready_i, done_valid_i, done_id_i,
        input  done_result_i, done_status_i, out_ready_i,
        output in_ready_o, ch_valid_o, ch_id_o,
        output out_valid_o, result_o, status_o, tag_o, busy_o
    );

    modport master (
        output flush_i, in_valid_i, in_channel_i, in_tag_i,
        output ch_ready_i, done_valid_i, done_id_i,
        output done_result_i, done_status_i, out_ready_i,
        input  in_ready_o, ch_valid_o, ch_id_o,
        input  out_valid_o, result_o, status_o, tag_o, busy_o
    );
endinterface

// File: rtl/fpnew_opgroup_reorder_block.sv
// In-order retirement buffer for results coming back from parallel FP slices.
// Define FPNEW_ROB_BYPASS_EN for zero-latency forwarding of a head completion.
module fpnew_opgroup_reorder_block #(
    parameter int unsigned NumChannels = 4,
    parameter int unsigned Width       = 32,
    parameter int unsigned Depth       = 4,
    parameter int unsigned TagWidth    = 8
) (
    input logic                          clk_i,
    input logic                          rst_i,
    fpnew_opgroup_reorder_block_if.slave bus
);
    localparam int unsigned IdW = $clog2(Depth);
    localparam int unsigned ChW = (NumChannels > 1) ? $clog2(NumChannels) : 1;

    typedef logic [IdW-1:0] id_t;
    typedef logic [IdW:0]   cnt_t;

    id_t                            head_q, head_d;
    id_t                            tail_q, tail_d;
    cnt_t                           count_q, count_d;
    logic [Depth-1:0]               alloc_q, alloc_d;
    logic [Depth-1:0]               cmpl_q, cmpl_d;
    logic [Depth-1:0][TagWidth-1:0] tag_q, tag_d;
    logic [Depth-1:0][Width-1:0]    res_q, res_d;
    logic [Depth-1:0][4:0]          stat_q, stat_d;

    logic                   full;
    logic                   ch_ok;
    logic                   sel_ready;
    logic                   accept;
    logic                   pop;
    logic                   head_done;
    logic                   out_valid;
    logic [NumChannels-1:0] done_hit;
    logic [NumChannels-1:0] ch_valid;
    logic                   byp_hit;
    logic [Width-1:0]       byp_res;
    logic [4:0]             byp_stat;

    // Free slots are counted from registered state only, so a pop never
    // makes room for an accept in the same cycle.
    assign full  = (count_q == cnt_t'(Depth));
    assign ch_ok = ({1'b0, bus.in_channel_i} < (ChW+1)'(NumChannels));
    assign sel_ready = ch_ok & bus.ch_ready_i[bus.in_channel_i];

    assign bus.in_ready_o = !full & sel_ready & !bus.flush_i;
    assign accept = bus.in_valid_i & bus.in_ready_o;

    always_comb begin
        ch_valid = '0;
        for (int c = 0; c < NumChannels; c++) begin
            ch_valid[c] = bus.in_valid_i & !full & !bus.flush_i
                        & (bus.in_channel_i == ChW'(c));
        end
    end

    assign bus.ch_valid_o = ch_valid;
    assign bus.ch_id_o    = tail_q;

    always_comb begin
        done_hit = '0;
        for (int c = 0; c < NumChannels; c++) begin
            done_hit[c] = bus.done_valid_i[c]
                        & alloc_q[bus.done_id_i[c]]
                        & !cmpl_q[bus.done_id_i[c]]
                        & !bus.flush_i;
        end
    end

    assign head_done = alloc_q[head_q] & cmpl_q[head_q];

`ifdef FPNEW_ROB_BYPASS_EN
    always_comb begin
        byp_hit  = 1'b0;
        byp_res  = '0;
        byp_stat = '0;
        for (int c = 0; c < NumChannels; c++) begin
            if (done_hit[c] && (bus.done_id_i[c] == head_q)) begin
                byp_hit  = 1'b1;
                byp_res  = bus.done_result_i[c];
                byp_stat = bus.done_status_i[c];
            end
        end
    end
`else
    assign byp_hit  = 1'b0;
    assign byp_res  = '0;
    assign byp_stat = '0;
`endif

    assign out_valid = head_done | byp_hit;
    assign pop       = out_valid & bus.out_ready_i & !bus.flush_i;

    always_comb begin
        bus.result_o = '0;
        bus.status_o = '0;
        bus.tag_o    = '0;
        if (head_done) begin
            bus.result_o = res_q[head_q];
            bus.status_o = stat_q[head_q];
            bus.tag_o    = tag_q[head_q];
        end else if (byp_hit) begin
            bus.result_o = byp_res;
            bus.status_o = byp_stat;
            bus.tag_o    = tag_q[head_q];
        end
    end

    assign bus.out_valid_o = out_valid;
    assign bus.busy_o      = (count_q != '0);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        alloc_d = alloc_q;
        cmpl_d  = cmpl_q;
        tag_d   = tag_q;
        res_d   = res_q;
        stat_d  = stat_q;

        for (int c = 0; c < NumChannels; c++) begin
            if (done_hit[c]) begin
                cmpl_d[bus.done_id_i[c]] = 1'b1;
                res_d[bus.done_id_i[c]]  = bus.done_result_i[c];
                stat_d[bus.done_id_i[c]] = bus.done_status_i[c];
            end
        end

        // A bypassed head completion is freed here without being kept.
        if (pop) begin
            alloc_d[head_q] = 1'b0;
            cmpl_d[head_q]  = 1'b0;
            head_d          = head_q + id_t'(1);
        end

        if (accept) begin
            alloc_d[tail_q] = 1'b1;
            cmpl_d[tail_q]  = 1'b0;
            tag_d[tail_q]   = bus.in_tag_i;
            tail_d          = tail_q + id_t'(1);
        end

        count_d = count_q + cnt_t'(accept) - cnt_t'(pop);

        if (bus.flush_i) begin
            alloc_d = '0;
            cmpl_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            alloc_q <= '0;
            cmpl_q  <= '0;
            tag_q   <= '0;
            res_q   <= '0;
            stat_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            alloc_q <= alloc_d;
            cmpl_q  <= cmpl_d;
            tag_q   <= tag_d;
            res_q   <= res_d;
            stat_q  <= stat_d;
        end
    end
endmodule

// File: doc/fpnew_opgroup_reorder_block.md
FPNEW_OPGROUP_REORDER_BLOCK -- requirements
Module: fpnew_opgroup_reorder_block

Interface
REQ-001 SHALL have parameter NumChannels, default 4: number of attached execution slices (range 1..16).
REQ-002 SHALL have parameter Width, default 32: result width in bits.
REQ-003 SHALL have parameter Depth, default 4: reorder entries, power of two, 2..32; IdW = $clog2(Depth), ChW = max(1,$clog2(NumChannels)).
REQ-004 SHALL have parameter TagWidth, default 8: opaque tag width.
REQ-005 SHALL have ports, one clock and an asynchronous active-high reset:
- clk_i  in  1  clock.
- rst_i  in  1  async reset, active-high.
- flush_i  in  1  drop all in-flight entries.
- in_valid_i  in  1  operation offered.
- in_channel_i  in  ChW  target slice.
- in_tag_i  in  TagWidth  operation tag.
- in_ready_o  out  1  operation accepted.
- ch_valid_o  out  NumChannels  one-hot dispatch valid.
- ch_id_o  out  IdW  entry id carried by the dispatched op.
- ch_ready_i  in  NumChannels  slice input ready.
- done_valid_i  in  NumChannels  slice completion strobe.
- done_id_i  in  NumChannels x IdW  completed entry id.
- done_result_i  in  NumChannels x Width  completed result.
- done_status_i  in  NumChannels x 5  fpnew_pkg::status_t flags.
- out_valid_o  out  1  in-order result valid.
- out_ready_i  in  1  downstream ready.
- result_o  out  Width  result.
- status_o  out  5  status flags.
- tag_o  out  TagWidth  tag.
- busy_o  out  1  any entry allocated.

Function
REQ-006 SHALL keep head, tail (IdW bits, wrap mod Depth) and count (IdW+1 bits); full = (count==Depth).
REQ-007 SHALL drive in_ready_o = !full & ch_ready_i[in_channel_i] & !flush_i; no same-cycle reuse of an entry freed by a pop.
REQ-008 SHALL drive ch_valid_o[c] = in_valid_i & !full & !flush_i & (in_channel_i==c); ch_id_o = tail.
REQ-009 SHALL on accept (in_valid_i & in_ready_o) store in_tag_i at entry tail, mark it allocated and pending, tail++.
REQ-010 SHALL on done_valid_i[c] for an allocated pending entry store result/status and mark it complete; completions from several channels in one cycle SHALL all be written (ids distinct by construction).
REQ-011 SHALL ignore completions addressing unallocated or already-complete entries and completions in the flush cycle.
REQ-012 SHALL assert out_valid_o when entry head is allocated and complete; result_o/status_o/tag_o from entry head; outputs SHALL be stable while out_valid_o & !out_ready_i.
REQ-013 SHALL on out_valid_o & out_ready_i free entry head, head++; simultaneous accept and pop SHALL leave count unchanged.
REQ-014 SHALL deliver results strictly in acceptance order regardless of completion order.
REQ-015 SHALL on flush_i clear all allocated/complete bits, head=tail=count=0 next cycle; flush wins over same-cycle accept, completion and pop.
REQ-016 SHALL drive busy_o = (count != 0).
REQ-017 SHALL drive result_o, status_o, tag_o to zero when out_valid_o is low.

Reset
REQ-018 SHALL on rst_i asynchronously clear head, tail, count, all entry state; outputs out_valid_o=0, busy_o=0, result_o=0, status_o=0, tag_o=0; in_ready_o, ch_valid_o follow REQ-007/008 with count=0.
REQ-019 SHALL discard all entries on reset mid-operation; no result emitted for pre-reset operations.

Configuration
REQ-020 SHALL support macro FPNEW_ROB_BYPASS_EN: when defined, a completion to the pending head entry SHALL drive out_valid_o and its data in the same cycle (zero-cycle latency), popping without storing if out_ready_i=1, else storing as complete; when undefined, minimum completion-to-out_valid_o latency SHALL be exactly one cycle.

Verification
REQ-021 Depth=4, accept tags 0x10,0x11,0x12 on channels 0,1,2; complete in order 2,0,1 -> out emits 0x10,0x11,0x12 in order, 0x10 one cycle after channel 0 done (no bypass).
REQ-022 Fill 4 entries, hold out_ready_i=0 -> in_ready_o=0, busy_o=1; then out_ready_i=1 with in_valid_i=1 -> one pop and, next cycle, one accept; count stays 4 after.
REQ-023 Channels 0 and 3 complete ids 1 and 0 same cycle -> both stored; outputs ids 0 then 1 on consecutive cycles with out_ready_i=1.
REQ-024 3 entries allocated, 1 complete, assert flush_i -> next cycle out_valid_o=0, busy_o=0, count=0; stale completion for id 1 afterwards ignored.
REQ-025 FPNEW_ROB_BYPASS_EN defined, single op, completion with out_ready_i=1 -> out_valid_o high same cycle, busy_o=0 next cycle.
REQ-026 Assert rst_i with 2 entries pending -> all outputs zero immediately; later completions produce no output.
